// File: rtl/spi_clkgen_pkg.sv
// Shared types and constants for the SPI clock-generator sequencer.
package spi_clkgen_pkg;

    localparam int DIV_W = 16;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OFF,
        ST_ON,
        ST_READY,
        ST_REL
    } state_t;

    // Width of a requester index; at least one bit even for tiny NREQ.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen_ctrl_if.sv
// Requester / clock-generator bundle shared by the sequencer and its users.
interface spi_clkgen_ctrl_if
    import spi_clkgen_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*DIV_W-1:0] req_div;
    logic [NREQ-1:0]       grant;
    logic                  clk_ready;
    logic                  spi_clk_en;
    logic [DIV_W-1:0]      spi_clk_div;
    logic                  busy;

    modport master (
        output req, req_div,
        input  grant, clk_ready, spi_clk_en, spi_clk_div, busy
    );

    modport slave (
        input  req, req_div,
        output grant, clk_ready, spi_clk_en, spi_clk_div, busy
    );

endinterface

// File: rtl/spi_rr_arb.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module spi_rr_arb
    import spi_clkgen_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  winner,
    output logic             valid
);
    // Candidate k is the requester k+1 places after the previous winner.
    logic [IDX_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0]  cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = IDX_W'((int'(last) + gi + 1) % NREQ);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                winner              = '0;
                winner[cand_idx[k]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_clkgen_ctrl.sv
// Sequencer that shares one SPI clock generator between NREQ requesters,
// reprogramming the divider only while the generator enable is held low.
module spi_clkgen_ctrl
    import spi_clkgen_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int OFF_CYCLES = 4,
    parameter int ON_CYCLES  = 4
) (
    input  logic             spi_clk,
    input  logic             spi_clk_rst_n,
    spi_clkgen_ctrl_if.slave bus
);
    localparam int               IDX_W    = idx_width(NREQ);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic             clk_ready_reg, clk_ready_next;
    logic             en_reg, en_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [IDX_W-1:0] last_reg, last_next;
    logic             busy_reg;

    logic [NREQ-1:0]  arb_winner;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [DIV_W-1:0] div_arr [NREQ];
    logic             owner_dropped;
    logic             fast_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_div
            assign div_arr[gi] = bus.req_div[gi*DIV_W +: DIV_W];
        end
    endgenerate

    spi_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.req),
        .last   (last_reg),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // One-hot winner to index, for the pointer and the divider mux.
    always_comb begin
        arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_winner[k]) arb_idx = IDX_W'(k);
        end
    end

    // The owner has let go once its request bit is low.
    assign owner_dropped = ~|(bus.req & grant_reg);
    // Handover without gating is only safe when the divider is unchanged.
    assign fast_ok       = arb_valid && (div_arr[arb_idx] == div_reg);

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        grant_next     = grant_reg;
        clk_ready_next = clk_ready_reg;
        en_next        = en_reg;
        div_next       = div_reg;
        last_next      = last_reg;
        case (state_reg)
            ST_IDLE: begin
                grant_next     = '0;
                en_next        = 1'b0;
                clk_ready_next = 1'b0;
                if (arb_valid) begin
                    state_next = ST_OFF;
                    grant_next = arb_winner;
                    div_next   = div_arr[arb_idx];
                    last_next  = arb_idx;
                    cnt_next   = OFF_LOAD;
                end
            end
            ST_OFF: begin
                en_next = 1'b0;
                if (owner_dropped) begin
                    state_next = ST_REL;
                    grant_next = '0;
                    cnt_next   = OFF_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = ST_ON;
                    en_next    = 1'b1;
                    cnt_next   = ON_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_ON: begin
                if (owner_dropped) begin
                    state_next = ST_REL;
                    grant_next = '0;
                    en_next    = 1'b0;
                    cnt_next   = OFF_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next     = ST_READY;
                    clk_ready_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_READY: begin
                if (owner_dropped) begin
                    if (fast_ok) begin
                        grant_next = arb_winner;
                        last_next  = arb_idx;
                    end else begin
                        state_next     = ST_REL;
                        grant_next     = '0;
                        clk_ready_next = 1'b0;
                        en_next        = 1'b0;
                        cnt_next       = OFF_LOAD;
                    end
                end
            end
            ST_REL: begin
                grant_next     = '0;
                clk_ready_next = 1'b0;
                en_next        = 1'b0;
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next     = ST_IDLE;
                grant_next     = '0;
                clk_ready_next = 1'b0;
                en_next        = 1'b0;
                cnt_next       = '0;
            end
        endcase
    end

    // State, counter and all outputs are registered; reset clears everything.
    always_ff @(posedge spi_clk or negedge spi_clk_rst_n) begin
        if (!spi_clk_rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            grant_reg     <= '0;
            clk_ready_reg <= 1'b0;
            en_reg        <= 1'b0;
            div_reg       <= '0;
            last_reg      <= IDX_W'(NREQ - 1);
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            grant_reg     <= grant_next;
            clk_ready_reg <= clk_ready_next;
            en_reg        <= en_next;
            div_reg       <= div_next;
            last_reg      <= last_next;
            busy_reg      <= (state_next != ST_IDLE);
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.clk_ready   = clk_ready_reg;
    assign bus.spi_clk_en  = en_reg;
    assign bus.spi_clk_div = div_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_spi_clkgen_ctrl.sv
// Scenario bench for spi_clkgen_ctrl with a grant/divider scoreboard.
module tb_spi_clkgen_ctrl;
    localparam int NREQ = 3;
    localparam int OFFC = 4;
    localparam int ONC  = 4;

    typedef struct {
        logic [NREQ-1:0] grant;
        logic [15:0]     div;
    } exp_t;

    logic spi_clk       = 1'b0;
    logic spi_clk_rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic [15:0] gen_cnt;

    spi_clkgen_ctrl_if #(.NREQ(NREQ)) bus ();

    spi_clkgen_ctrl #(
        .NREQ       (NREQ),
        .OFF_CYCLES (OFFC),
        .ON_CYCLES  (ONC)
    ) dut (
        .spi_clk       (spi_clk),
        .spi_clk_rst_n (spi_clk_rst_n),
        .bus           (bus)
    );

    always #5 spi_clk = ~spi_clk;

    // Reference clock generator: one divided period is (div+1) spi_clk cycles.
    always @(posedge spi_clk) begin
        if (!bus.spi_clk_en) gen_cnt <= 16'd0;
        else if (gen_cnt >= bus.spi_clk_div) gen_cnt <= 16'd0;
        else gen_cnt <= gen_cnt + 16'd1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge spi_clk);
    endtask

    task automatic do_reset();
        spi_clk_rst_n = 1'b0;
        bus.req       = '0;
        bus.req_div   = '0;
        exp_q.delete();
        cyc(2);
        spi_clk_rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_div = '0;
        cyc(2);
        total++; if (bus.grant !== '0) begin bad++; $display("FAIL rst_grant: got %b want 0", bus.grant); end
        total++; if (bus.clk_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.clk_ready); end
        total++; if (bus.spi_clk_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", bus.spi_clk_en); end
        total++; if (bus.spi_clk_div !== 16'd0) begin bad++; $display("FAIL rst_div: got %0d want 0", bus.spi_clk_div); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        spi_clk_rst_n = 1'b1;
        cyc(2);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        exp_t e; int n; int per;
        do_reset();
        bus.req_div = {16'd0, 16'd0, 16'd5};
        bus.req     = 3'b001;
        exp_q.push_back('{3'b001, 16'd5});
        cyc(1);
        e = exp_q.pop_front();
        $display("txn single: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
        total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t1_grant: got %b want %b", bus.grant, e.grant); end
        total++; if (bus.spi_clk_div !== e.div) begin bad++; $display("FAIL t1_div: got %0d want %0d", bus.spi_clk_div, e.div); end
        cyc(OFFC - 1);
        total++; if (bus.spi_clk_en !== 1'b0) begin bad++; $display("FAIL t1_en_early: got %b want 0", bus.spi_clk_en); end
        cyc(1);
        total++; if (bus.spi_clk_en !== 1'b1) begin bad++; $display("FAIL t1_en_rise: got %b want 1", bus.spi_clk_en); end
        cyc(ONC - 1);
        total++; if (bus.clk_ready !== 1'b0) begin bad++; $display("FAIL t1_ready_early: got %b want 0", bus.clk_ready); end
        cyc(1);
        total++; if (bus.clk_ready !== 1'b1) begin bad++; $display("FAIL t1_ready_rise: got %b want 1", bus.clk_ready); end
        total++; if (bus.spi_clk_div !== 16'd5) begin bad++; $display("FAIL t1_div_hold: got %0d want 5", bus.spi_clk_div); end
        n = 0;
        while (gen_cnt != 16'd0 && n < 20) begin cyc(1); n++; end
        cyc(1); per = 1;
        while (gen_cnt != 16'd0 && per < 20) begin cyc(1); per++; end
        total++; if (per != 6) begin bad++; $display("FAIL t1_period: got %0d want 6", per); end
        bus.req = '0;
        cyc(1);
        total++; if ({bus.grant, bus.clk_ready, bus.spi_clk_en} !== 5'b0) begin bad++; $display("FAIL t1_release: got %b want 00000", {bus.grant, bus.clk_ready, bus.spi_clk_en}); end
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin cyc(1); n++; end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t1_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_switch();
        exp_t e; int n; int low;
        do_reset();
        bus.req_div = {16'd0, 16'd7, 16'd3};
        bus.req     = 3'b011;
        exp_q.push_back('{3'b001, 16'd3});
        cyc(1);
        e = exp_q.pop_front();
        $display("txn switch first: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
        total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t2_grant0: got %b want %b", bus.grant, e.grant); end
        total++; if (bus.spi_clk_div !== e.div) begin bad++; $display("FAIL t2_div0: got %0d want %0d", bus.spi_clk_div, e.div); end
        n = 0;
        while (bus.clk_ready !== 1'b1 && n < 20) begin cyc(1); n++; end
        total++; if (bus.clk_ready !== 1'b1) begin bad++; $display("FAIL t2_ready0: got %b want 1", bus.clk_ready); end
        exp_q.push_back('{3'b010, 16'd7});
        bus.req = 3'b010;
        cyc(1);
        total++; if ({bus.grant, bus.clk_ready, bus.spi_clk_en} !== 5'b0) begin bad++; $display("FAIL t2_drop: got %b want 00000", {bus.grant, bus.clk_ready, bus.spi_clk_en}); end
        n = 1; low = 1;
        while (bus.grant === '0 && n < 30) begin
            cyc(1); n++;
            if (bus.spi_clk_en === 1'b0) low++;
        end
        total++; if (n != 2 + OFFC) begin bad++; $display("FAIL t2_grant_lat: got %0d want %0d", n, 2 + OFFC); end
        e = exp_q.pop_front();
        $display("txn switch second: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
        total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t2_grant1: got %b want %b", bus.grant, e.grant); end
        total++; if (bus.spi_clk_div !== e.div) begin bad++; $display("FAIL t2_div1: got %0d want %0d", bus.spi_clk_div, e.div); end
        total++; if (bus.spi_clk_en !== 1'b0) begin bad++; $display("FAIL t2_en_at_div: got %b want 0", bus.spi_clk_en); end
        while (bus.spi_clk_en === 1'b0 && n < 60) begin
            cyc(1); n++;
            if (bus.spi_clk_en === 1'b0) low++;
        end
        total++; if (low < OFFC) begin bad++; $display("FAIL t2_low_len: got %0d want >=%0d", low, OFFC); end
        n = 0;
        while (bus.clk_ready !== 1'b1 && n < 20) begin cyc(1); n++; end
        total++; if (bus.clk_ready !== 1'b1) begin bad++; $display("FAIL t2_ready1: got %b want 1", bus.clk_ready); end
        bus.req = '0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin cyc(1); n++; end
    endtask

    task automatic test_fast_path();
        exp_t e; int n; int viol;
        do_reset();
        bus.req_div = {16'd0, 16'd2, 16'd2};
        bus.req     = 3'b011;
        exp_q.push_back('{3'b001, 16'd2});
        cyc(1);
        e = exp_q.pop_front();
        $display("txn fast first: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
        total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t3_grant0: got %b want %b", bus.grant, e.grant); end
        n = 0;
        while (bus.clk_ready !== 1'b1 && n < 20) begin cyc(1); n++; end
        total++; if (bus.clk_ready !== 1'b1) begin bad++; $display("FAIL t3_ready0: got %b want 1", bus.clk_ready); end
        exp_q.push_back('{3'b010, 16'd2});
        bus.req = 3'b010;
        viol = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (bus.spi_clk_en !== 1'b1 || bus.clk_ready !== 1'b1) viol++;
            if (i == 0) begin
                e = exp_q.pop_front();
                $display("txn fast handover: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
                total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t3_handover: got %b want %b", bus.grant, e.grant); end
            end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL t3_continuous: got %0d gaps want 0", viol); end
        bus.req = '0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin cyc(1); n++; end
    endtask

    task automatic test_abort();
        exp_t e; int n; int rel; int viol;
        do_reset();
        bus.req_div = {16'd0, 16'd0, 16'd4};
        bus.req     = 3'b001;
        exp_q.push_back('{3'b001, 16'd4});
        cyc(1);
        e = exp_q.pop_front();
        $display("txn abort: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
        total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t4_grant: got %b want %b", bus.grant, e.grant); end
        n = 0;
        while (bus.spi_clk_en !== 1'b1 && n < 20) begin cyc(1); n++; end
        total++; if (bus.spi_clk_en !== 1'b1) begin bad++; $display("FAIL t4_on: got %b want 1", bus.spi_clk_en); end
        bus.req = '0;
        cyc(1);
        total++; if ({bus.grant, bus.clk_ready, bus.spi_clk_en} !== 5'b0) begin bad++; $display("FAIL t4_abort: got %b want 00000", {bus.grant, bus.clk_ready, bus.spi_clk_en}); end
        rel = 0; viol = 0;
        while (bus.busy === 1'b1 && rel < 30) begin
            if (bus.spi_clk_en !== 1'b0 || bus.clk_ready !== 1'b0) viol++;
            rel++;
            cyc(1);
        end
        total++; if (rel != OFFC) begin bad++; $display("FAIL t4_rel_len: got %0d want %0d", rel, OFFC); end
        total++; if (viol != 0) begin bad++; $display("FAIL t4_rel_outputs: got %0d bad cycles want 0", viol); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t4_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_fairness();
        exp_t e; int n; logic [NREQ-1:0] owner;
        do_reset();
        bus.req_div = {16'd1, 16'd2, 16'd3};
        bus.req     = 3'b111;
        exp_q.push_back('{3'b001, 16'd3});
        exp_q.push_back('{3'b010, 16'd2});
        exp_q.push_back('{3'b100, 16'd1});
        exp_q.push_back('{3'b001, 16'd3});
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (bus.grant === '0 && n < 30) begin cyc(1); n++; end
            e = exp_q.pop_front();
            $display("txn fair %0d: grant=%b div=%0d", r, bus.grant, bus.spi_clk_div);
            total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t5_order%0d: got %b want %b", r, bus.grant, e.grant); end
            total++; if (bus.spi_clk_div !== e.div) begin bad++; $display("FAIL t5_div%0d: got %0d want %0d", r, bus.spi_clk_div, e.div); end
            n = 0;
            while (bus.clk_ready !== 1'b1 && n < 20) begin cyc(1); n++; end
            owner   = bus.grant;
            bus.req = bus.req & ~owner;
            cyc(1);
            bus.req = bus.req | owner;
        end
        bus.req = '0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin cyc(1); n++; end
    endtask

    task automatic test_reset_mid_on();
        exp_t e; int n;
        do_reset();
        bus.req_div = {16'd0, 16'd0, 16'd5};
        bus.req     = 3'b001;
        n = 0;
        while (bus.spi_clk_en !== 1'b1 && n < 20) begin cyc(1); n++; end
        cyc(1);
        spi_clk_rst_n = 1'b0;
        #1;
        total++; if (bus.grant !== '0) begin bad++; $display("FAIL t6_grant: got %b want 0", bus.grant); end
        total++; if (bus.spi_clk_en !== 1'b0) begin bad++; $display("FAIL t6_en: got %b want 0", bus.spi_clk_en); end
        total++; if (bus.spi_clk_div !== 16'd0) begin bad++; $display("FAIL t6_div: got %0d want 0", bus.spi_clk_div); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL t6_busy: got %b want 0", bus.busy); end
        cyc(1);
        spi_clk_rst_n = 1'b1;
        exp_q.push_back('{3'b001, 16'd5});
        cyc(1);
        e = exp_q.pop_front();
        $display("txn after reset: grant=%b div=%0d", bus.grant, bus.spi_clk_div);
        total++; if (bus.grant !== e.grant) begin bad++; $display("FAIL t6_regrant: got %b want %b", bus.grant, e.grant); end
        total++; if (bus.spi_clk_div !== e.div) begin bad++; $display("FAIL t6_rediv: got %0d want %0d", bus.spi_clk_div, e.div); end
        cyc(OFFC - 1);
        total++; if (bus.spi_clk_en !== 1'b0) begin bad++; $display("FAIL t6_en_early: got %b want 0", bus.spi_clk_en); end
        cyc(1);
        total++; if (bus.spi_clk_en !== 1'b1) begin bad++; $display("FAIL t6_en_rise: got %b want 1", bus.spi_clk_en); end
        cyc(ONC - 1);
        total++; if (bus.clk_ready !== 1'b0) begin bad++; $display("FAIL t6_ready_early: got %b want 0", bus.clk_ready); end
        cyc(1);
        total++; if (bus.clk_ready !== 1'b1) begin bad++; $display("FAIL t6_ready_rise: got %b want 1", bus.clk_ready); end
        bus.req = '0;
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin cyc(1); n++; end
    endtask

    initial begin
        bus.req     = '0;
        bus.req_div = '0;
        test_reset();
        test_single();
        test_switch();
        test_fast_path();
        test_abort();
        test_fairness();
        test_reset_mid_on();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_clkgen_ctrl.md
# spi_clkgen_ctrl

Sequencer and round-robin arbiter that owns the `spi_clk_en` / `spi_clk_div` configuration inputs of the SPI clock generator and shares the divided clock between `NREQ` requesters that each need their own divider.
- On each grant it performs a glitch-safe reconfiguration: it forces the enable low, holds it low long enough for the generator's enable synchronizer to settle, presents the new divider, raises the enable, and waits for the divided clock to start.
- It then signals `clk_ready` to the winner.
- The block sits in the `spi_clk` domain, between the SPI masters and `spi_clkgen`.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters. Range 2..8.
- `OFF_CYCLES`, default 4: minimum number of `spi_clk` cycles `spi_clk_en` is held low before a new divider is enabled. Range 3..15.
- `ON_CYCLES`, default 4: number of `spi_clk` cycles from `spi_clk_en` rising to `clk_ready`. Covers 2-flop sync + edge detect + enable flop. Range 4..15.

Ports (reset is `spi_clk_rst_n`, asynchronous, active-low; clock is `spi_clk`):
- `spi_clk` in 1: clock.
- `spi_clk_rst_n` in 1: asynchronous active-low reset.
- `req` in NREQ: per-requester request level. Held high for the whole use; dropping it releases the clock.
- `req_div` in NREQ*16: per-requester divider; slice i is bits [16i+15:16i]. Sampled only at grant.
- `grant` out NREQ: one-hot or zero; the current owner.
- `clk_ready` out 1: the divided clock is running with the owner's divider.
- `spi_clk_en` out 1: to `spi_clkgen`.
- `spi_clk_div` out 16: to `spi_clkgen`. Stable whenever `spi_clk_en` is high.
- `busy` out 1: state is not IDLE.

## Operation
States:
- **IDLE**
  - `spi_clk_en`=0, `grant`=0.
  - If any `req` is high, choose winner w (round-robin) and go to OFF.
- **OFF**
  - On entry: `grant[w]`=1, `spi_clk_div` <= `req_div[w]`, counter loaded with `OFF_CYCLES`-1.
  - `spi_clk_en`=0.
  - Go to ON when the counter reaches 0.
- **ON**
  - `spi_clk_en`=1, counter loaded with `ON_CYCLES`-1.
  - Go to READY when the counter reaches 0.
- **READY**
  - `clk_ready`=1, `spi_clk_en`=1.
  - If `req[w]` falls, go to REL.
- **REL**
  - `clk_ready`=0, `grant`=0, `spi_clk_en`=0.
  - Counter loaded with `OFF_CYCLES`-1.
  - When the counter reaches 0, go to IDLE. Re-arbitration happens in IDLE, so every switch is separated by at least `OFF_CYCLES` of enable low.

Fast path:
- Applies in READY when `req[w]` falls, the next round-robin winner n≠w has `req_div[n]` equal to the current `spi_clk_div`, and `req[n]` is high.
- The block hands over directly without disabling the clock: `grant` switches to n on the next cycle, `clk_ready` stays 1, and it remains in READY.

Arbitration:
- Round-robin pointer `last` holds the index of the previous winner; reset value `NREQ`-1, so req0 wins first.
- Search order is `last`+1, `last`+2, … modulo `NREQ`. `last` updates on every grant.

Boundary rules:
- Owner drops `req` during OFF or ON: abort, go to REL (enable forced low), `clk_ready` never asserts.
- `req_div` changes while granted: ignored until the next grant.
- Divider 0 is legal: the generator bypasses it.
- Other requesters asserting or deasserting do not affect the current owner (no preemption).
- Reset mid-operation: all outputs return to reset values immediately; the next grant performs a full OFF sequence.

## Timing
- Reset values: `grant`=0, `clk_ready`=0, `spi_clk_en`=0, `spi_clk_div`=16'd0, `busy`=0, state IDLE, counter 0.
- All outputs are registered; there is no combinational path from `req` to any output.
- `req` rising in cycle t with the block in IDLE:
  - `grant` and `spi_clk_div` valid at t+1.
  - `spi_clk_en` rises at t+1+`OFF_CYCLES`.
  - `clk_ready` rises at t+1+`OFF_CYCLES`+`ON_CYCLES`.
- `req[w]` falling in cycle t (READY, no fast path): `clk_ready`, `grant` and `spi_clk_en` are all 0 at t+1.
  - A pending request gets `grant` at t+2+`OFF_CYCLES`.
- Fast-path handover: `grant` changes at t+1, `spi_clk_en` is never deasserted.
- `spi_clk_div` changes only in IDLE→OFF transitions, i.e. only while `spi_clk_en`=0.

## Structure
- Shared package `spi_clkgen_pkg`: state enum (IDLE, OFF, ON, READY, REL), the divider width constant 16, and the counter width 4.
- One sub-module, `spi_rr_arb`: combinational round-robin next-winner logic. Inputs `req` and `last`; outputs a one-hot winner and a valid flag.
- The FSM, counter and registered outputs live in the top module.

## Test plan
1. Single request: after reset, `req`=01, `req_div[0]`=16'd5. Expect:
   - `grant`=01 one cycle later.
   - `spi_clk_en` high 4 cycles after that, `clk_ready` 4 cycles after that.
   - `spi_clk_div`=5 throughout. A `spi_clkgen` model produces a period-6 clock.
2. Switch with different divider: `req`=11, `req_div`=3 and 7; drop `req[0]` in READY. Expect:
   - `spi_clk_en` low for 4 or more cycles.
   - `grant`=10, `spi_clk_div`=7 while `spi_clk_en`=0.
   - `clk_ready` reasserts.
3. Fast path: both dividers 16'd2; drop `req[0]` in READY. Expect `grant` 01→10 in one cycle, `spi_clk_en` and `clk_ready` continuously high.
4. Abort: drop `req[0]` during ON. Expect `clk_ready` never asserts, then REL with `spi_clk_en`=0 for 4 cycles, then IDLE with `busy`=0.
5. Fairness, `NREQ`=3: all `req` held high, each requester releases once it reaches READY. Expect grant order 0, 1, 2, 0.
6. Reset mid-ON: assert `spi_clk_rst_n`=0. Expect all outputs 0 immediately; after release, the same request repeats the full OFF→ON timing from test 1.
